// File: rtl/alu_issue_if.sv
// Handshake and operand bus between the decode stage, the forwarding network,
// the alu_issue_stage and the ALU.
interface alu_issue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned OP_W   = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic [REG_W-1:0]  in_rs_idx;
  logic [REG_W-1:0]  in_rt_idx;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic [15:0]       in_imm;
  logic              in_use_imm;
  logic [REG_W-1:0]  in_rd_idx;
  logic              in_reg_write;
  logic              fwd_mem_en;
  logic [REG_W-1:0]  fwd_mem_idx;
  logic [DATA_W-1:0] fwd_mem_data;
  logic              fwd_wb_en;
  logic [REG_W-1:0]  fwd_wb_idx;
  logic [DATA_W-1:0] fwd_wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   alu_control;
  logic [DATA_W-1:0] alu_oper1;
  logic [DATA_W-1:0] alu_oper2;
  logic [REG_W-1:0]  out_rd_idx;
  logic              out_reg_write;

  modport master (
    output in_valid, in_opcode, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
           in_imm, in_use_imm, in_rd_idx, in_reg_write,
           fwd_mem_en, fwd_mem_idx, fwd_mem_data,
           fwd_wb_en, fwd_wb_idx, fwd_wb_data, flush, out_ready,
    input  in_ready, out_valid, alu_control, alu_oper1, alu_oper2,
           out_rd_idx, out_reg_write
  );

  modport slave (
    input  in_valid, in_opcode, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
           in_imm, in_use_imm, in_rd_idx, in_reg_write,
           fwd_mem_en, fwd_mem_idx, fwd_mem_data,
           fwd_wb_en, fwd_wb_idx, fwd_wb_data, flush, out_ready,
    output in_ready, out_valid, alu_control, alu_oper1, alu_oper2,
           out_rd_idx, out_reg_write
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: resolves forwarded/immediate operands and holds them in a
// main register plus a one-entry skid buffer so upstream ready is registered.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned OP_W   = 4
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = OP_W'(0),
    OP_SUB = OP_W'(1),
    OP_MUL = OP_W'(2),
    OP_AND = OP_W'(3),
    OP_OR  = OP_W'(4)
  } op_t;

  typedef struct packed {
    logic [OP_W-1:0]   control;
    logic [DATA_W-1:0] oper1;
    logic [DATA_W-1:0] oper2;
    logic [REG_W-1:0]  rd_idx;
    logic              reg_write;
  } entry_t;

  state_t            state, state_n;
  entry_t            main_q, skid_q, in_entry;
  logic              in_ready_q;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, main_from_skid;
  logic [DATA_W-1:0] opa, opb, imm_ext;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = (state != S_EMPTY) & bus.out_ready;

  // EX/MEM has priority over WB; register 0 is hardwired and never forwarded.
  always_comb begin
    opa = bus.in_rs_val;
    if (bus.fwd_mem_en && bus.fwd_mem_idx == bus.in_rs_idx && bus.in_rs_idx != '0)
      opa = bus.fwd_mem_data;
    else if (bus.fwd_wb_en && bus.fwd_wb_idx == bus.in_rs_idx && bus.in_rs_idx != '0)
      opa = bus.fwd_wb_data;

    opb = bus.in_rt_val;
    if (bus.fwd_mem_en && bus.fwd_mem_idx == bus.in_rt_idx && bus.in_rt_idx != '0)
      opb = bus.fwd_mem_data;
    else if (bus.fwd_wb_en && bus.fwd_wb_idx == bus.in_rt_idx && bus.in_rt_idx != '0)
      opb = bus.fwd_wb_data;

    if (bus.in_opcode == OP_AND || bus.in_opcode == OP_OR)
      imm_ext = {{(DATA_W-16){1'b0}}, bus.in_imm};
    else
      imm_ext = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};

    in_entry.control   = bus.in_opcode;
    in_entry.oper1     = opa;
    in_entry.oper2     = bus.in_use_imm ? imm_ext : opb;
    in_entry.rd_idx    = bus.in_rd_idx;
    in_entry.reg_write = bus.in_reg_write;
  end

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (bus.flush) begin
      state_n = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_fire) begin
          state_n   = S_ONE;
          load_main = 1'b1;
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_n   = S_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_n = S_EMPTY;
          end
        end
        S_TWO: if (out_fire) begin
          state_n        = S_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_n = S_EMPTY;
      endcase
    end
  end

  // in_ready is precomputed from the next occupancy so it is a clean flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != S_TWO);
      if (load_main) main_q <= main_from_skid ? skid_q : in_entry;
      if (load_skid) skid_q <= in_entry;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = (state != S_EMPTY);
  assign bus.alu_control   = main_q.control;
  assign bus.alu_oper1     = main_q.oper1;
  assign bus.alu_oper2     = main_q.oper2;
  assign bus.out_rd_idx    = main_q.rd_idx;
  assign bus.out_reg_write = main_q.reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic clk;
  logic reset;
  int   tests;
  int   errors;

  alu_issue_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] rsv, input logic [31:0] rtv,
                           input logic [15:0] imm, input logic ui,
                           input logic [4:0] rd, input logic rw);
    bus.in_valid     = 1'b1;
    bus.in_opcode    = op;
    bus.in_rs_idx    = rs;
    bus.in_rt_idx    = rt;
    bus.in_rs_val    = rsv;
    bus.in_rt_val    = rtv;
    bus.in_imm       = imm;
    bus.in_use_imm   = ui;
    bus.in_rd_idx    = rd;
    bus.in_reg_write = rw;
  endtask

  task automatic clear_fwd();
    bus.fwd_mem_en   = 1'b0;
    bus.fwd_mem_idx  = '0;
    bus.fwd_mem_data = '0;
    bus.fwd_wb_en    = 1'b0;
    bus.fwd_wb_idx   = '0;
    bus.fwd_wb_data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h expected 1", bus.in_ready); end
    tests++; if (bus.alu_control !== 4'h0 || bus.alu_oper1 !== 32'h0 || bus.alu_oper2 !== 32'h0)
      begin errors++; $display("FAIL reset_data: got ctl=%0h o1=%0h o2=%0h expected 0/0/0", bus.alu_control, bus.alu_oper1, bus.alu_oper2); end
    tests++; if (bus.out_rd_idx !== 5'h0 || bus.out_reg_write !== 1'b0)
      begin errors++; $display("FAIL reset_rd: got rd=%0h rw=%0h expected 0/0", bus.out_rd_idx, bus.out_reg_write); end
    reset = 1'b0;
    step();
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset: got rdy=%0h vld=%0h expected 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    set_instr(4'd0, 5'd1, 5'd2, 32'd5, 32'd7, 16'h0, 1'b0, 5'd3, 1'b1);
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h expected 1", bus.out_valid); end
    tests++; if (bus.alu_control !== 4'd0 || bus.alu_oper1 !== 32'd5 || bus.alu_oper2 !== 32'd7)
      begin errors++; $display("FAIL basic_ops: got ctl=%0h o1=%0h o2=%0h expected 0/5/7", bus.alu_control, bus.alu_oper1, bus.alu_oper2); end
    tests++; if (bus.out_rd_idx !== 5'd3 || bus.out_reg_write !== 1'b1)
      begin errors++; $display("FAIL basic_rd: got rd=%0h rw=%0h expected 3/1", bus.out_rd_idx, bus.out_reg_write); end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0h expected 0", bus.out_valid); end
  endtask

  task automatic test_forward();
    bus.out_ready = 1'b1;
    set_instr(4'd0, 5'd3, 5'd3, 32'h1, 32'h2, 16'h0, 1'b0, 5'd4, 1'b1);
    bus.fwd_mem_en = 1'b1; bus.fwd_mem_idx = 5'd3; bus.fwd_mem_data = 32'h10;
    bus.fwd_wb_en  = 1'b1; bus.fwd_wb_idx  = 5'd3; bus.fwd_wb_data  = 32'h20;
    step();
    tests++; if (bus.alu_oper1 !== 32'h10 || bus.alu_oper2 !== 32'h10)
      begin errors++; $display("FAIL fwd_mem_priority: got o1=%0h o2=%0h expected 10/10", bus.alu_oper1, bus.alu_oper2); end
    bus.fwd_mem_en = 1'b0;
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.alu_oper1 !== 32'h20 || bus.alu_oper2 !== 32'h20)
      begin errors++; $display("FAIL fwd_wb: got v=%0h o1=%0h o2=%0h expected 1/20/20", bus.out_valid, bus.alu_oper1, bus.alu_oper2); end
    set_instr(4'd0, 5'd0, 5'd0, 32'h55, 32'h66, 16'h0, 1'b0, 5'd4, 1'b1);
    bus.fwd_mem_en = 1'b1; bus.fwd_mem_idx = 5'd0; bus.fwd_mem_data = 32'h99;
    bus.fwd_wb_en  = 1'b1; bus.fwd_wb_idx  = 5'd0; bus.fwd_wb_data  = 32'h77;
    step();
    tests++; if (bus.alu_oper1 !== 32'h55 || bus.alu_oper2 !== 32'h66)
      begin errors++; $display("FAIL fwd_r0: got o1=%0h o2=%0h expected 55/66", bus.alu_oper1, bus.alu_oper2); end
    set_instr(4'd0, 5'd6, 5'd7, 32'h11, 32'h22, 16'h0, 1'b0, 5'd4, 1'b1);
    bus.fwd_mem_idx = 5'd7; bus.fwd_mem_data = 32'hAA;
    bus.fwd_wb_idx  = 5'd6; bus.fwd_wb_data  = 32'hBB;
    step();
    tests++; if (bus.alu_oper1 !== 32'hBB || bus.alu_oper2 !== 32'hAA)
      begin errors++; $display("FAIL fwd_split: got o1=%0h o2=%0h expected bb/aa", bus.alu_oper1, bus.alu_oper2); end
    bus.in_valid = 1'b0;
    clear_fwd();
    step();
  endtask

  task automatic test_imm();
    bus.out_ready = 1'b1;
    set_instr(4'd1, 5'd1, 5'd2, 32'h5, 32'h1234, 16'hFFFF, 1'b1, 5'd1, 1'b1);
    step();
    tests++; if (bus.alu_control !== 4'd1 || bus.alu_oper2 !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL imm_sub_sext: got ctl=%0h o2=%0h expected 1/ffffffff", bus.alu_control, bus.alu_oper2); end
    set_instr(4'd4, 5'd1, 5'd2, 32'h5, 32'h1234, 16'hFFFF, 1'b1, 5'd1, 1'b1);
    step();
    tests++; if (bus.alu_control !== 4'd4 || bus.alu_oper2 !== 32'h0000_FFFF)
      begin errors++; $display("FAIL imm_or_zext: got ctl=%0h o2=%0h expected 4/ffff", bus.alu_control, bus.alu_oper2); end
    set_instr(4'd3, 5'd1, 5'd2, 32'h5, 32'h1234, 16'h8000, 1'b1, 5'd1, 1'b1);
    step();
    tests++; if (bus.alu_oper2 !== 32'h0000_8000)
      begin errors++; $display("FAIL imm_and_zext: got %0h expected 8000", bus.alu_oper2); end
    set_instr(4'd0, 5'd1, 5'd2, 32'h5, 32'h1234, 16'h8000, 1'b1, 5'd1, 1'b1);
    step();
    tests++; if (bus.alu_oper2 !== 32'hFFFF_8000 || bus.alu_oper1 !== 32'h5)
      begin errors++; $display("FAIL imm_add_sext: got o1=%0h o2=%0h expected 5/ffff8000", bus.alu_oper1, bus.alu_oper2); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    set_instr(4'd2, 5'd1, 5'd2, 32'h101, 32'h0, 16'h0, 1'b0, 5'd1, 1'b1);
    step();
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.alu_oper1 !== 32'h101)
      begin errors++; $display("FAIL stall_first: got rdy=%0h vld=%0h o1=%0h expected 1/1/101", bus.in_ready, bus.out_valid, bus.alu_oper1); end
    set_instr(4'd2, 5'd1, 5'd2, 32'h102, 32'h0, 16'h0, 1'b0, 5'd2, 1'b0);
    step();
    tests++; if (bus.in_ready !== 1'b0 || bus.alu_oper1 !== 32'h101)
      begin errors++; $display("FAIL stall_full: got rdy=%0h o1=%0h expected 0/101", bus.in_ready, bus.alu_oper1); end
    set_instr(4'd2, 5'd1, 5'd2, 32'h103, 32'h0, 16'h0, 1'b0, 5'd3, 1'b1);
    step();
    tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.alu_oper1 !== 32'h101 || bus.out_rd_idx !== 5'd1)
      begin errors++; $display("FAIL stall_hold: got rdy=%0h vld=%0h o1=%0h rd=%0h expected 0/1/101/1", bus.in_ready, bus.out_valid, bus.alu_oper1, bus.out_rd_idx); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.alu_oper1 !== 32'h102 || bus.out_rd_idx !== 5'd2 || bus.out_reg_write !== 1'b0)
      begin errors++; $display("FAIL release_second: got rdy=%0h vld=%0h o1=%0h rd=%0h rw=%0h expected 1/1/102/2/0", bus.in_ready, bus.out_valid, bus.alu_oper1, bus.out_rd_idx, bus.out_reg_write); end
    step();
    tests++; if (bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL release_drain: got %0h expected 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    set_instr(4'd0, 5'd1, 5'd2, 32'h201, 32'h0, 16'h0, 1'b0, 5'd1, 1'b1);
    step();
    set_instr(4'd0, 5'd1, 5'd2, 32'h202, 32'h0, 16'h0, 1'b0, 5'd2, 1'b1);
    step();
    tests++; if (bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL flush_setup: got rdy=%0h expected 0", bus.in_ready); end
    set_instr(4'd0, 5'd1, 5'd2, 32'h203, 32'h0, 16'h0, 1'b0, 5'd3, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_clear: got vld=%0h rdy=%0h expected 0/1", bus.out_valid, bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus.out_valid !== 1'b0)
        begin errors++; $display("FAIL flush_no_issue: cycle %0d got vld=%0h expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    set_instr(4'd4, 5'd1, 5'd2, 32'h301, 32'h401, 16'h0, 1'b0, 5'd9, 1'b1);
    step();
    set_instr(4'd4, 5'd1, 5'd2, 32'h302, 32'h402, 16'h0, 1'b0, 5'd10, 1'b1);
    step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL midreset_hs: got vld=%0h rdy=%0h expected 0/1", bus.out_valid, bus.in_ready); end
    tests++; if (bus.alu_control !== 4'h0 || bus.alu_oper1 !== 32'h0 || bus.alu_oper2 !== 32'h0 || bus.out_rd_idx !== 5'h0 || bus.out_reg_write !== 1'b0)
      begin errors++; $display("FAIL midreset_data: got ctl=%0h o1=%0h o2=%0h rd=%0h rw=%0h expected all 0", bus.alu_control, bus.alu_oper1, bus.alu_oper2, bus.out_rd_idx, bus.out_reg_write); end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();
    tests++; if (bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL midreset_after: got vld=%0h expected 0", bus.out_valid); end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    reset  = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_opcode    = '0;
    bus.in_rs_idx    = '0;
    bus.in_rt_idx    = '0;
    bus.in_rs_val    = '0;
    bus.in_rt_val    = '0;
    bus.in_imm       = '0;
    bus.in_use_imm   = 1'b0;
    bus.in_rd_idx    = '0;
    bus.in_reg_write = 1'b0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    clear_fwd();

    test_reset();
    test_basic();
    test_forward();
    test_imm();
    test_back_to_back();
    test_flush();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
